// File: rtl/fifo_mac_array.sv
// rtl/fifo_mac_array.sv - systolic FIFO-fed matrix-vector multiply-accumulate array
module fifo_mac_array #(
    parameter int NUM_FIFOS  = 9,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifoRdata,
    input  logic [NUM_FIFOS-1:0]            fifoEmpty,
    output logic [NUM_FIFOS-1:0]            fifoRden,
    output logic [(NUM_FIFOS-1)*ACC_WIDTH-1:0] result,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int ROWS = NUM_FIFOS - 1;
    localparam int LAST = DEPTH + ROWS - 1;
    localparam int CW   = $clog2(LAST + 1);
    localparam int PW   = 2 * DATA_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]  acc_q [ROWS];
    logic [ACC_WIDTH-1:0]  acc_d [ROWS];
    logic [DATA_WIDTH-1:0] bdly_q [ROWS-1];
    logic [DATA_WIDTH-1:0] bdly_d [ROWS-1];
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [NUM_FIFOS-1:0]  rden;
    logic [DATA_WIDTH-1:0] b_bus;
    int                    cnt_i;

    assign b_bus = fifoRdata[ROWS*DATA_WIDTH +: DATA_WIDTH];
    assign cnt_i = int'(cnt_q);

    // Pop schedule: B for the first DEPTH cycles, row i skewed by i cycles; nothing in IDLE.
    always_comb begin
        rden = '0;
        if (state_q == RUN) begin
            if (cnt_i < DEPTH) rden[ROWS] = 1'b1;
            for (int i = 0; i < ROWS; i++) begin
                if (cnt_i >= i && cnt_i < i + DEPTH) rden[i] = 1'b1;
            end
        end
    end

    // Next-state: FSM, counter, B skew chain, MAC windows, status flags.
    always_comb begin
        logic [DATA_WIDTH-1:0] a_op;
        logic [DATA_WIDTH-1:0] b_op;
        logic [PW-1:0]         prod;
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        a_op    = '0;
        b_op    = '0;
        prod    = '0;
        for (int i = 0; i < ROWS; i++) acc_d[i] = acc_q[i];
        bdly_d[0] = b_bus;
        for (int j = 1; j < ROWS - 1; j++) bdly_d[j] = bdly_q[j-1];
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    for (int i = 0; i < ROWS; i++) acc_d[i] = '0;
                end
            end
            RUN: begin
                if (|(rden & fifoEmpty)) err_d = 1'b1;
                for (int i = 0; i < ROWS; i++) begin
                    if (cnt_i >= i + 1 && cnt_i <= i + DEPTH) begin
                        a_op     = fifoRdata[i*DATA_WIDTH +: DATA_WIDTH];
                        b_op     = (i == 0) ? b_bus : bdly_q[(i == 0) ? 0 : i-1];
                        prod     = {{DATA_WIDTH{1'b0}}, a_op} * {{DATA_WIDTH{1'b0}}, b_op};
                        acc_d[i] = acc_q[i] + ACC_WIDTH'(prod);
                    end
                end
                if (cnt_i == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; asynchronous reset discards any pass in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < ROWS; i++) acc_q[i] <= '0;
            for (int j = 0; j < ROWS - 1; j++) bdly_q[j] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < ROWS; i++) acc_q[i] <= acc_d[i];
            for (int j = 0; j < ROWS - 1; j++) bdly_q[j] <= bdly_d[j];
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_result
        assign result[g*ACC_WIDTH +: ACC_WIDTH] = acc_q[g];
    end

    assign fifoRden = rden;
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fifo_mac_array.sv
// tb/tb_fifo_mac_array.sv - randomized self-checking bench for fifo_mac_array
module tb_fifo_mac_array;

    localparam int NF   = 9;
    localparam int ROWS = NF - 1;
    localparam int K    = 8;
    localparam int DW   = 8;
    localparam int AW   = 24;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [NF*DW-1:0]    fifo_rdata;
    logic [NF-1:0]       fifo_empty;
    logic [NF-1:0]       fifo_rden;
    logic [ROWS*AW-1:0]  result;
    logic                busy;
    logic                done;
    logic                err;

    fifo_mac_array #(
        .NUM_FIFOS(NF), .DEPTH(K), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .fifoRdata(fifo_rdata), .fifoEmpty(fifo_empty), .fifoRden(fifo_rden),
        .result(result), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [NF][2*K];
    int            wr [NF];
    int            rd [NF];
    logic [NF-1:0] rden_seen;
    int            am [ROWS][K];
    int            bm [K];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] ref_c(input int i);
        longint s = 0;
        for (int k = 0; k < K; k++) s += longint'(am[i][k]) * longint'(bm[k]);
        return AW'(s % (longint'(1) << AW));
    endfunction

    task automatic update_empty();
        for (int j = 0; j < NF; j++) fifo_empty[j] = (rd[j] == wr[j]);
    endtask

    task automatic load_fifos(input bit skip3);
        for (int j = 0; j < NF; j++) begin
            rd[j] = 0;
            wr[j] = 0;
            if (!(skip3 && j == 3)) begin
                for (int k = 0; k < K; k++)
                    mem[j][k] = (j == ROWS) ? DW'(bm[k]) : DW'(am[j][k]);
                wr[j] = K;
            end
        end
        update_empty();
    endtask

    // One clock: FIFO model pops on the enables seen last cycle, data visible next cycle.
    task automatic step();
        @(posedge clk);
        #1;
        for (int j = 0; j < NF; j++) begin
            if (rden_seen[j] && rd[j] != wr[j]) begin
                fifo_rdata[j*DW +: DW] = mem[j][rd[j]];
                rd[j] = rd[j] + 1;
            end
        end
        update_empty();
        @(negedge clk);
        rden_seen = fifo_rden;
    endtask

    function automatic logic [NF-1:0] exp_rden(input int c);
        logic [NF-1:0] v = '0;
        if (c < K) v[ROWS] = 1'b1;
        for (int i = 0; i < ROWS; i++) if (c >= i && c < i + K) v[i] = 1'b1;
        return v;
    endfunction

    task automatic run_pass(input bit mid_start, input bit skip3, input bit exp_err);
        int c;
        chk("idle_rden", 64'(fifo_rden), 64'(0));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("done_drop", 64'(done), 64'(0));
        c = 0;
        while (busy && c < 40) begin
            chk("rden", 64'(fifo_rden), 64'(exp_rden(c)));
            if (mid_start && c == 5) start = 1'b1;
            step();
            start = 1'b0;
            c++;
        end
        chk("busy_cycles", 64'(c), 64'(K + ROWS));
        chk("done", 64'(done), 64'(1));
        chk("err", 64'(err), 64'(exp_err));
        chk("idle_rden_after", 64'(fifo_rden), 64'(0));
        for (int i = 0; i < ROWS; i++)
            if (!(skip3 && i == 3))
                chk($sformatf("C%0d", i), 64'(result[i*AW +: AW]), 64'(ref_c(i)));
    endtask

    task automatic set_const(input int a, input int b);
        for (int i = 0; i < ROWS; i++) for (int k = 0; k < K; k++) am[i][k] = a;
        for (int k = 0; k < K; k++) bm[k] = b;
    endtask

    task automatic set_scn2();
        for (int i = 0; i < ROWS; i++) for (int k = 0; k < K; k++) am[i][k] = i + 1;
        for (int k = 0; k < K; k++) bm[k] = k + 1;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        fifo_rdata = '0;
        rden_seen  = '0;
        for (int j = 0; j < NF; j++) begin rd[j] = 0; wr[j] = 0; end
        update_empty();
        repeat (2) @(negedge clk);
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_rden", 64'(fifo_rden), 64'(0));
        rst_n = 1'b1;
        step();

        // all ones
        set_const(1, 1);
        load_fifos(1'b0);
        run_pass(1'b0, 1'b0, 1'b0);
        chk("C0_eq8", 64'(result[AW-1:0]), 64'(8));

        // row i = i+1, B = 1..8
        set_scn2();
        load_fifos(1'b0);
        run_pass(1'b0, 1'b0, 1'b0);
        chk("C7_288", 64'(result[7*AW +: AW]), 64'(288));
        step();
        step();
        chk("hold", 64'(result[AW-1:0]), 64'(ref_c(0)));

        // max operands
        set_const(255, 255);
        load_fifos(1'b0);
        run_pass(1'b0, 1'b0, 1'b0);
        chk("C7_max", 64'(result[7*AW +: AW]), 64'(520200));

        // start pulsed mid-run is ignored
        set_scn2();
        load_fifos(1'b0);
        run_pass(1'b1, 1'b0, 1'b0);

        // FIFO 3 empty: sticky error, pass still completes
        load_fifos(1'b1);
        run_pass(1'b0, 1'b1, 1'b1);

        // randomized passes
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < ROWS; i++)
                for (int k = 0; k < K; k++) am[i][k] = int'($urandom_range(0, 255));
            for (int k = 0; k < K; k++) bm[k] = int'($urandom_range(0, 255));
            load_fifos(1'b0);
            run_pass(1'b0, 1'b0, 1'b0);
        end

        // reset at run cycle 5
        set_const(1, 1);
        load_fifos(1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_result", 64'(result), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_err", 64'(err), 64'(0));
        chk("mid_rst_rden", 64'(fifo_rden), 64'(0));
        fifo_rdata = '0;
        rden_seen  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_rden", 64'(fifo_rden), 64'(0));
        set_const(1, 1);
        load_fifos(1'b0);
        run_pass(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
